reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Decode-stage hazard unit directly downstream of the IR register-address producer.
- Consumes the source register addresses add_A, add_B and add_mem for the instruction being issued. Register 0 means "no operand".
- Tracks per-register countdowns for results still in flight and holds issue (stall) until every source is safe to read.
- Also blocks write-after-write overtakes and counts stall cycles for performance monitoring.

Parameters:
- NREG, 32, number of architectural registers; address width is clog2(NREG) = 5.
- LAT_W, 3, width of the per-register countdown and of the dst_lat input.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- issue_valid  input  1  decode holds an instruction requesting issue.
- add_A  input  5  first source register; 0 = unused.
- add_B  input  5  second source register; 0 = unused.
- add_mem  input  5  store-data source register; 0 = unused.
- dst_addr  input  5  destination register of the issuing instruction; 0 = no write.
- dst_lat  input  LAT_W  cycles from issue until the result is in the register file.
- flush  input  1  pipeline flush (branch/jump redirect); kills all in-flight tracking.
- stall  output  1  combinational; issue must hold this cycle.
- issue_ok  output  1  combinational; issue_valid & ~stall & ~flush.
- busy_mask  output  NREG  registered; bit r = countdown[r] != 0.
- stall_cnt  output  CNT_W  registered, saturating count of stall cycles.

Behaviour:
- State: countdown[r] of LAT_W bits for r = 1..NREG-1. countdown[0] is hard-wired 0, so register 0 is never busy.
- Reset (async, rst=1):
  - all countdowns = 0; busy_mask = 0; stall_cnt = 0.
  - stall and issue_ok follow their equations, so they are 0 while issue_valid = 0.
- Per-cycle update, in priority order:
  - flush=1: all countdowns cleared next edge; any issue that cycle is ignored; issue_ok = 0.
  - issue_ok=1, dst_addr != 0, dst_lat != 0: countdown[dst_addr] <= dst_lat. This overrides that register's decrement in the same cycle.
  - Every other nonzero countdown decrements by 1; zero stays zero (no underflow).
  - dst_lat = 0 or dst_addr = 0: no entry is created.
- Read hazard: src_busy(s) = (s != 0) & (countdown[s] > RDY), where:
  - RDY = 0 by default.
  - RDY = 1 with FORWARDING_EN.
- Write-after-write hazard: waw = (dst_addr != 0) & (countdown[dst_addr] > dst_lat). A newer, shorter write may not overtake an older, longer one.
- stall = issue_valid & (src_busy(add_A) | src_busy(add_B) | src_busy(add_mem) | waw).
  - Purely combinational from current state and inputs; zero cycles of latency to the decode stage.
- Same register used as source and destination: only the read check applies to the source; the destination is rewritten on the issue edge.
- Countdown reaching RDY on edge N: an instruction presented in cycle N issues without stall.
- stall_cnt increments on each edge where stall=1 and flush=0, and saturates at all-ones.
- busy_mask reflects post-edge countdown state.
- Reset asserted mid-stall: clears all state immediately; issue is released once rst deasserts.

Optional Feature:
- Macro FORWARDING_EN.
- Defined: RDY = 1. A value due in the register file next cycle is treated as available through the forwarding network, so a dependent ALU op behind a 1-cycle-from-writeback producer does not stall.
- Undefined: RDY = 0. Sources wait until countdown = 0.
- busy_mask is unaffected in both cases.

Decomposition:
- Shared package cpu_pkg holds:
  - REG_AW = 5 and NREG = 32.
  - Latency constants: LAT_ALU = 3, LAT_LOAD = 4, LAT_NONE = 0.
  - The typedef reg_addr_t.
- One sub-module, sb_counter: a single register's countdown (load, decrement, clear, busy flag), instantiated NREG-1 times by generate.
- Hazard compare and stall counter stay in the top module.

Test Plan:
- Reset, then issue add_A=8, add_B=9 with no busy regs -> stall=0, issue_ok=1, busy_mask=0.
- Issue dst_addr=5, dst_lat=3; next cycle issue add_A=5:
  - default: stall for 3 cycles, then issue_ok on cycle 4.
  - FORWARDING_EN: 2 stall cycles.
  - stall_cnt = 3 or 2 respectively.
- Issue dst 7 with lat 4; next cycle issue dst 7 with lat 1 and no sources -> waw stall until countdown[7] <= 1, then issue; busy_mask[7] set again.
- Load countdown[12]=4; assert flush together with issue_valid, dst 3 -> issue_ok=0; next cycle busy_mask=0; countdown[3] not set.
- Any source or destination equal to 0 with issue_valid=1 -> never stalls; busy_mask[0] stays 0 after issuing dst 0 with lat 4.
- Assert rst asynchronously mid-stall (countdown[5]=2) -> busy_mask=0 and stall_cnt=0 immediately; stall=0 after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU decode definitions: register-file geometry and result latencies.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int REG_AW = 5;   // register address width
    localparam int NREG   = 32;  // architectural registers

    // Cycles from issue until a result lands in the register file.
    localparam int LAT_ALU  = 3;
    localparam int LAT_LOAD = 4;
    localparam int LAT_NONE = 0;

    typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/sb_counter.sv
// One register's in-flight countdown: load on issue, decrement to zero, clear on flush.
// Latency: load/clear take effect on the next clk edge; busy is registered alongside cnt.
// Backpressure: none; the owner decides when to load.
// Ports: clk/rst (async active-high), load + load_val (new in-flight result),
//        clear (flush), cnt (current countdown), busy (cnt != 0).
module sb_counter
    import cpu_pkg::*;
#(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             clear,
    output logic [LAT_W-1:0] cnt,
    output logic             busy
);

    logic [LAT_W-1:0] cnt_d, cnt_q;
    logic             busy_d, busy_q;

    // Clear beats load; a load overrides this cycle's decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - LAT_W'(1);
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign cnt  = cnt_q;
    assign busy = busy_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage register scoreboard: RAW/WAW hazard detection and stall-cycle counter.
// Latency: stall/issue_ok are combinational (0 cycles); busy_mask/stall_cnt are registered.
// Backpressure: stall holds the issuing instruction until all sources are readable.
// Ports: clk, rst (async active-high); issue_valid, add_A/add_B/add_mem (sources, 0 = unused),
//        dst_addr/dst_lat (destination and result latency), flush; outputs stall, issue_ok,
//        busy_mask (bit r = register r has a result in flight), stall_cnt (saturating).
// Build option: define FORWARDING_EN to treat a value one cycle from writeback as readable.
module reg_scoreboard #(
    parameter int NREG  = cpu_pkg::NREG,
    parameter int LAT_W = 3,
    parameter int CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic [cpu_pkg::REG_AW-1:0] add_A,
    input  logic [cpu_pkg::REG_AW-1:0] add_B,
    input  logic [cpu_pkg::REG_AW-1:0] add_mem,
    input  logic [cpu_pkg::REG_AW-1:0] dst_addr,
    input  logic [LAT_W-1:0]          dst_lat,
    input  logic                      flush,
    output logic                      stall,
    output logic                      issue_ok,
    output logic [NREG-1:0]           busy_mask,
    output logic [CNT_W-1:0]          stall_cnt
);
    import cpu_pkg::*;

    // Countdown value at or below which a source may be read.
`ifdef FORWARDING_EN
    localparam logic [LAT_W-1:0] RDY = LAT_W'(1);
`else
    localparam logic [LAT_W-1:0] RDY = '0;
`endif

    logic [LAT_W-1:0] cnt [NREG];
    logic [LAT_W-1:0] cnt_a, cnt_b, cnt_m, cnt_dst;
    logic             busy_a, busy_b, busy_m, waw;
    logic             load_en;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    // Register 0 is never a real producer or consumer.
    assign cnt[0]       = '0;
    assign busy_mask[0] = 1'b0;

    assign load_en = issue_ok && (dst_addr != '0) && (dst_lat != '0);

    genvar r;
    generate
        for (r = 1; r < NREG; r++) begin : g_reg
            sb_counter #(.LAT_W(LAT_W)) u_cnt (
                .clk      (clk),
                .rst      (rst),
                .load     (load_en && (dst_addr == reg_addr_t'(r))),
                .load_val (dst_lat),
                .clear    (flush),
                .cnt      (cnt[r]),
                .busy     (busy_mask[r])
            );
        end
    endgenerate

    always_comb begin
        cnt_a   = cnt[add_A];
        cnt_b   = cnt[add_B];
        cnt_m   = cnt[add_mem];
        cnt_dst = cnt[dst_addr];

        busy_a = (add_A   != '0) && (cnt_a > RDY);
        busy_b = (add_B   != '0) && (cnt_b > RDY);
        busy_m = (add_mem != '0) && (cnt_m > RDY);
        // A shorter new write must not land before an older, longer one.
        // When dst is also a source, the read check alone governs it.
        waw    = (dst_addr != '0) && (cnt_dst > dst_lat);

        stall    = issue_valid && (busy_a || busy_b || busy_m || waw);
        issue_ok = issue_valid && !stall && !flush;

        stall_cnt_d = stall_cnt_q;
        if (stall && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: reset, RAW stall, WAW stall, flush, register 0, async reset.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 3 units after posedge.
// Backpressure: n/a.
module tb_reg_scoreboard;

    localparam int TNREG = 32;
    localparam int TLAT  = 3;
    localparam int TCNT  = 32;

`ifdef FORWARDING_EN
    localparam int NST = 2;
`else
    localparam int NST = 3;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             issue_valid = 1'b0;
    logic [4:0]       add_A = '0;
    logic [4:0]       add_B = '0;
    logic [4:0]       add_mem = '0;
    logic [4:0]       dst_addr = '0;
    logic [TLAT-1:0]  dst_lat = '0;
    logic             flush = 1'b0;
    logic             stall;
    logic             issue_ok;
    logic [TNREG-1:0] busy_mask;
    logic [TCNT-1:0]  stall_cnt;

    int errors = 0;
    int checks = 0;
    int exp_sc = 0;

    reg_scoreboard #(.NREG(TNREG), .LAT_W(TLAT), .CNT_W(TCNT)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .add_A       (add_A),
        .add_B       (add_B),
        .add_mem     (add_mem),
        .dst_addr    (dst_addr),
        .dst_lat     (dst_lat),
        .flush       (flush),
        .stall       (stall),
        .issue_ok    (issue_ok),
        .busy_mask   (busy_mask),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        add_A = '0; add_B = '0; add_mem = '0;
        dst_addr = '0; dst_lat = '0; flush = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #3;
        chk("rst_busy", busy_mask, 32'h0);
        chk("rst_scnt", stall_cnt, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_issue_ok", {31'b0, issue_ok}, 32'h0);
        rst = 1'b0;

        // No busy registers: sources issue immediately
        cyc();
        issue_valid = 1'b1; add_A = 5'd8; add_B = 5'd9;
        #2;
        chk("free_stall", {31'b0, stall}, 32'h0);
        chk("free_issue_ok", {31'b0, issue_ok}, 32'h1);
        chk("free_busy", busy_mask, 32'h0);

        // RAW: producer on r5 with ALU latency, consumer next cycle
        cyc(); idle();
        issue_valid = 1'b1; dst_addr = 5'd5; dst_lat = 3'(cpu_pkg::LAT_ALU);
        #2;
        chk("raw_prod_ok", {31'b0, issue_ok}, 32'h1);
        cyc();
        dst_addr = '0; dst_lat = '0; add_A = 5'd5;
        #2;
        chk("raw_busy5", busy_mask, 32'h0000_0020);
        for (int k = 0; k < NST; k++) begin
            chk("raw_stall", {31'b0, stall}, 32'h1);
            cyc();
            exp_sc++;
            #2;
        end
        chk("raw_release", {31'b0, issue_ok}, 32'h1);
        chk("raw_scnt", stall_cnt, 32'(NST));

        // WAW: long write to r7, then a shorter write to r7 must wait
        cyc(); idle();
        issue_valid = 1'b1; dst_addr = 5'd7; dst_lat = 3'(cpu_pkg::LAT_LOAD);
        #2;
        chk("waw_first_ok", {31'b0, issue_ok}, 32'h1);
        cyc();
        dst_lat = 3'd1;
        #2;
        for (int k = 0; k < 3; k++) begin
            chk("waw_stall", {31'b0, stall}, 32'h1);
            cyc();
            exp_sc++;
            #2;
        end
        chk("waw_release", {31'b0, issue_ok}, 32'h1);
        cyc(); idle();
        #2;
        chk("waw_busy7", busy_mask, 32'h0000_0080);
        chk("waw_scnt", stall_cnt, 32'(exp_sc));
        cyc();
        #2;
        chk("waw_drain", busy_mask, 32'h0);

        // Flush kills in-flight r12 and the issue presented with it
        issue_valid = 1'b1; dst_addr = 5'd12; dst_lat = 3'd4;
        #2;
        cyc();
        flush = 1'b1; dst_addr = 5'd3; dst_lat = 3'd2; add_A = 5'd12;
        #2;
        chk("flush_issue_ok", {31'b0, issue_ok}, 32'h0);
        chk("flush_stall", {31'b0, stall}, 32'h1);
        chk("flush_busy12", busy_mask, 32'h0000_1000);
        cyc(); idle();
        #2;
        chk("flush_cleared", busy_mask, 32'h0);
        chk("flush_scnt", stall_cnt, 32'(exp_sc));

        // Register 0 as source and destination never stalls or tracks
        issue_valid = 1'b1; dst_lat = 3'd4;
        #2;
        chk("r0_stall", {31'b0, stall}, 32'h0);
        chk("r0_issue_ok", {31'b0, issue_ok}, 32'h1);
        cyc(); idle();
        #2;
        chk("r0_busy", busy_mask, 32'h0);

        // Store-data source hazard
        issue_valid = 1'b1; dst_addr = 5'd10; dst_lat = 3'd2;
        #2;
        cyc();
        dst_addr = '0; dst_lat = '0; add_mem = 5'd10;
        #2;
        chk("mem_stall", {31'b0, stall}, 32'h1);
        cyc(); idle();
        exp_sc++;
        #2;
        chk("mem_scnt", stall_cnt, 32'(exp_sc));
        repeat (3) cyc();

        // Async reset in the middle of a stall on r5
        issue_valid = 1'b1; dst_addr = 5'd5; dst_lat = 3'd3;
        #2;
        cyc();
        dst_addr = '0; dst_lat = '0; add_A = 5'd5;
        #2;
        chk("ar_stall_pre", {31'b0, stall}, 32'h1);
        cyc();
        exp_sc++;
        #2;
        chk("ar_busy_pre", busy_mask, 32'h0000_0020);
        chk("ar_scnt_pre", stall_cnt, 32'(exp_sc));
        rst = 1'b1;
        #1;
        chk("ar_busy", busy_mask, 32'h0);
        chk("ar_scnt", stall_cnt, 32'h0);
        chk("ar_stall", {31'b0, stall}, 32'h0);
        cyc();
        rst = 1'b0;
        #2;
        chk("ar_post_stall", {31'b0, stall}, 32'h0);
        chk("ar_post_issue", {31'b0, issue_ok}, 32'h1);
        cyc(); idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
